// File: rtl/mdu_hilo_pkg.sv
// Shared encodings and default latencies for the HI/LO multiply/divide unit.
package mdu_hilo_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_RSV6  = 3'd6,
    MD_RSV7  = 3'd7
  } md_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } md_state_e;

  localparam int MUL_LAT_DEF = 5;
  localparam int DIV_LAT_DEF = 10;

  // True for ops that occupy the unit for a latency window.
  function automatic logic is_md_op(input md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_hilo_arith.sv
// Combinational multiply/divide datapath: produces {hi,lo} from latched operands.
module md_arith
  import mdu_hilo_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  md_op_e      op,
  output logic [63:0] res,
  output logic        div_by_zero
);

  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, b_div, q_mag, r_mag, q_res, r_res;
  logic        sgn;

  // Signed divide is done on magnitudes so the 0x80000000 / -1 case wraps
  // cleanly and divide-by-zero never reaches the divider.
  always_comb begin
    sgn    = (op == MD_DIV);
    prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u = {32'd0, a} * {32'd0, b};
    a_mag  = (sgn && a[31]) ? -a : a;
    b_mag  = (sgn && b[31]) ? -b : b;
    b_div  = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag  = a_mag / b_div;
    r_mag  = a_mag % b_div;
    q_res  = (sgn && (a[31] ^ b[31])) ? -q_mag : q_mag;
    r_res  = (sgn && a[31]) ? -r_mag : r_mag;
    div_by_zero = ((op == MD_DIV) || (op == MD_DIVU)) && (b == 32'd0);
    case (op)
      MD_MULT:         res = prod_s;
      MD_MULTU:        res = prod_u;
      MD_DIV, MD_DIVU: res = {r_res, q_res};
      default:         res = 64'd0;
    endcase
  end

endmodule

// File: rtl/mdu_hilo.sv
// Multi-cycle MULT/DIV unit with HI/LO registers and a busy window that models
// latency; the result itself is combinational from the latched operands.
module mdu_hilo
  import mdu_hilo_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT) + 1;

  md_state_e   state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [31:0] a_q, b_q, a_n, b_n, hi_n, lo_n;
  md_op_e      op_q, op_n, op_in;
  logic [63:0] res;
  logic        dbz;

  assign op_in = md_op_e'(op);
  assign busy  = (state == S_RUN);

  md_arith u_arith (
    .a           (a_q),
    .b           (b_q),
    .op          (op_q),
    .res         (res),
    .div_by_zero (dbz)
  );

  // Next-state: accept/MTHI/MTLO in IDLE, count down and commit in RUN.
  // Starts during RUN (including the commit cycle) are dropped.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    a_n     = a_q;
    b_n     = b_q;
    op_n    = op_q;
    hi_n    = hi;
    lo_n    = lo;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (is_md_op(op_in)) begin
            a_n     = rs_data;
            b_n     = rt_data;
            op_n    = op_in;
            state_n = S_RUN;
            cnt_n   = ((op_in == MD_MULT) || (op_in == MD_MULTU)) ? CW'(MUL_LAT - 1)
                                                                  : CW'(DIV_LAT - 1);
          end else if (op_in == MD_MTHI) begin
            hi_n = rs_data;
          end else if (op_in == MD_MTLO) begin
            lo_n = rs_data;
          end
        end
      end
      S_RUN: begin
        if (cnt == '0) begin
          state_n = S_IDLE;
          if (!dbz) {hi_n, lo_n} = res;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State, counter, operand latches and HI/LO; async reset aborts any op.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= MD_MULT;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      a_q   <= a_n;
      b_q   <= b_n;
      op_q  <= op_n;
      hi    <= hi_n;
      lo    <= lo_n;
    end
  end

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed bench for mdu_hilo: latency windows, arithmetic, MTHI/MTLO,
// ignored issues and async reset abort.
module tb_mdu_hilo;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs_data = 32'd0;
  logic [31:0] rt_data = 32'd0;
  logic        busy;
  logic [31:0] hi, lo;

  int checks = 0;
  int passed = 0;

  mdu_hilo #(.MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data),
    .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Present one issue for a single rising edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Count busy cycles after an accept edge, sampling on falling edges.
  task automatic wait_busy(output int n);
    n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else passed++;
    checks++; if (hi !== 32'd0) $display("FAIL reset_hi got %08h want 00000000", hi); else passed++;
    checks++; if (lo !== 32'd0) $display("FAIL reset_lo got %08h want 00000000", lo); else passed++;
    reset = 1'b1;
  endtask

  task automatic test_mult;
    int n;
    issue(3'd0, 32'hFFFFFFFE, 32'h3);
    wait_busy(n);
    checks++; if (n != 5) $display("FAIL mult_busy got %0d want 5", n); else passed++;
    checks++; if (hi !== 32'hFFFFFFFF) $display("FAIL mult_hi got %08h want FFFFFFFF", hi); else passed++;
    checks++; if (lo !== 32'hFFFFFFFA) $display("FAIL mult_lo got %08h want FFFFFFFA", lo); else passed++;
  endtask

  task automatic test_multu;
    int n;
    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_busy(n);
    checks++; if (n != 5) $display("FAIL multu_busy got %0d want 5", n); else passed++;
    checks++; if (hi !== 32'hFFFFFFFE) $display("FAIL multu_hi got %08h want FFFFFFFE", hi); else passed++;
    checks++; if (lo !== 32'h00000001) $display("FAIL multu_lo got %08h want 00000001", lo); else passed++;
  endtask

  task automatic test_div;
    int n;
    issue(3'd2, 32'hFFFFFFF9, 32'd2);
    wait_busy(n);
    checks++; if (n != 10) $display("FAIL div_busy got %0d want 10", n); else passed++;
    checks++; if (lo !== 32'hFFFFFFFD) $display("FAIL div_lo got %08h want FFFFFFFD", lo); else passed++;
    checks++; if (hi !== 32'hFFFFFFFF) $display("FAIL div_hi got %08h want FFFFFFFF", hi); else passed++;
    // 7 / -2: quotient -3, remainder +1 (sign of dividend)
    issue(3'd2, 32'd7, 32'hFFFFFFFE);
    wait_busy(n);
    checks++; if (lo !== 32'hFFFFFFFD) $display("FAIL div_neg_lo got %08h want FFFFFFFD", lo); else passed++;
    checks++; if (hi !== 32'h00000001) $display("FAIL div_neg_hi got %08h want 00000001", hi); else passed++;
    // Overflow case wraps without trapping
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_busy(n);
    checks++; if (lo !== 32'h80000000) $display("FAIL div_ovf_lo got %08h want 80000000", lo); else passed++;
    checks++; if (hi !== 32'h00000000) $display("FAIL div_ovf_hi got %08h want 00000000", hi); else passed++;
    // DIVU 100/7 = 14 r 2
    issue(3'd3, 32'd100, 32'd7);
    wait_busy(n);
    checks++; if (n != 10) $display("FAIL divu_busy got %0d want 10", n); else passed++;
    checks++; if (lo !== 32'd14) $display("FAIL divu_lo got %08h want 0000000e", lo); else passed++;
    checks++; if (hi !== 32'd2) $display("FAIL divu_hi got %08h want 00000002", hi); else passed++;
  endtask

  task automatic test_divu_zero;
    int n;
    issue(3'd4, 32'h11, 32'h0);
    checks++; if (busy !== 1'b0) $display("FAIL mthi_busy got %0b want 0", busy); else passed++;
    checks++; if (hi !== 32'h11) $display("FAIL mthi_hi got %08h want 00000011", hi); else passed++;
    checks++; if (lo !== 32'd14) $display("FAIL mthi_lo_kept got %08h want 0000000e", lo); else passed++;
    issue(3'd5, 32'h22, 32'h0);
    checks++; if (busy !== 1'b0) $display("FAIL mtlo_busy got %0b want 0", busy); else passed++;
    checks++; if (lo !== 32'h22) $display("FAIL mtlo_lo got %08h want 00000022", lo); else passed++;
    issue(3'd3, 32'd5, 32'd0);
    wait_busy(n);
    checks++; if (n != 10) $display("FAIL divz_busy got %0d want 10", n); else passed++;
    checks++; if (hi !== 32'h11) $display("FAIL divz_hi got %08h want 00000011", hi); else passed++;
    checks++; if (lo !== 32'h22) $display("FAIL divz_lo got %08h want 00000022", lo); else passed++;
  endtask

  task automatic test_reserved;
    issue(3'd6, 32'hDEADBEEF, 32'd1);
    checks++; if (busy !== 1'b0) $display("FAIL rsv_busy got %0b want 0", busy); else passed++;
    checks++; if (hi !== 32'h11 || lo !== 32'h22)
      $display("FAIL rsv_hilo got %08h_%08h want 00000011_00000022", hi, lo); else passed++;
  endtask

  task automatic test_busy_issue;
    int n;
    issue(3'd0, 32'd3, 32'd4);
    n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 50) begin
      n++;
      if (n == 2) begin
        start = 1'b1; op = 3'd2; rs_data = 32'd100; rt_data = 32'd7;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    checks++; if (n != 5) $display("FAIL bb_busy got %0d want 5", n); else passed++;
    checks++; if (hi !== 32'd0) $display("FAIL bb_hi got %08h want 00000000", hi); else passed++;
    checks++; if (lo !== 32'd12) $display("FAIL bb_lo got %08h want 0000000c", lo); else passed++;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) $display("FAIL bb_no_second got busy %0b want 0", busy); else passed++;
  endtask

  task automatic test_reset_mid;
    int n;
    issue(3'd4, 32'h55, 32'd0);
    issue(3'd2, 32'd100, 32'd7);
    n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 4) begin
      n++;
      if (n < 4) @(negedge clk);
    end
    checks++; if (n != 4) $display("FAIL rm_reach got %0d want 4", n); else passed++;
    #2 reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL rm_busy got %0b want 0", busy); else passed++;
    checks++; if (hi !== 32'd0) $display("FAIL rm_hi got %08h want 00000000", hi); else passed++;
    checks++; if (lo !== 32'd0) $display("FAIL rm_lo got %08h want 00000000", lo); else passed++;
    @(negedge clk);
    reset = 1'b1;
    repeat (15) @(negedge clk);
    checks++; if (busy !== 1'b0) $display("FAIL rm_after_busy got %0b want 0", busy); else passed++;
    checks++; if (hi !== 32'd0 || lo !== 32'd0)
      $display("FAIL rm_no_commit got %08h_%08h want 00000000_00000000", hi, lo); else passed++;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_divu_zero();
    test_reserved();
    test_busy_issue();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
